// File: rtl/dcs_reg_resp_streamer.sv
// DSI peripheral read-response engine: decodes DCS/generic reads, looks up a 4-entry response
// table, requests the bus on host turnaround and streams long-packet payload words.
module dcs_reg_resp_streamer #(
  parameter logic [1:0]  VC      = 2'd0,
  parameter int unsigned MAX_LEN = 8
) (
  input  logic        clk_periph,
  input  logic        rstn,
  input  logic [23:0] mipi_periph_rx_cmd,
  input  logic        mipi_periph_rx_cmd_valid,
  input  logic        mipi_periph_dphy_direction,
  input  logic        mipi_periph_tx_cmd_ack,
  input  logic        mipi_periph_tx_payload_en,
  input  logic        mipi_periph_tx_payload_en_last,
  input  logic        cfg_wr_en,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [31:0] mipi_periph_tx_payload,
  output logic [1:0]  mipi_periph_tx_cmd_vc,
  output logic [5:0]  mipi_periph_tx_cmd_data_type,
  output logic [15:0] mipi_periph_tx_cmd_byte_count,
  output logic        mipi_periph_tx_cmd_req,
  output logic        busy,
  output logic        err_unmapped,
  output logic        err_overrun
);

  typedef enum logic [2:0] {StIdle, StLookup, StArmed, StReq, StStream} state_e;

  localparam logic [3:0] MaxLen4 = 4'(MAX_LEN);
  localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

  // Response table
  logic [7:0]               key_q [4];
  logic [7:0]               len_q [4];
  logic [MAX_LEN-1:0][7:0]  tbl_q [4];

  logic [1:0] cfg_entry;
  logic [3:0] cfg_field;
  assign cfg_entry = cfg_addr[5:4];
  assign cfg_field = cfg_addr[3:0];

  always_ff @(posedge clk_periph or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        len_q[i] <= '0;
        tbl_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      if (cfg_field == 4'd0) begin
        key_q[cfg_entry] <= cfg_wdata;
      end else if (cfg_field == 4'd1) begin
        len_q[cfg_entry] <= cfg_wdata;
      end else begin
        for (int j = 0; j < MAX_LEN; j++) begin
          if (int'(cfg_field) == j + 2) tbl_q[cfg_entry][j] <= cfg_wdata;
        end
      end
    end
  end

  // Packs word widx of a byte buffer; bytes at or beyond len read as zero.
  function automatic logic [31:0] pack_word(input logic [MAX_LEN-1:0][7:0] b,
                                            input logic [3:0] len, input logic [3:0] widx);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if ((j / 4 == int'(widx)) && (j < int'(len))) w[8*(j%4) +: 8] = b[j];
    end
    return w;
  endfunction

  state_e                  state_q, state_d;
  logic                    dir_q;
  logic                    gen_q, gen_d;
  logic [7:0]              addr_q, addr_d;
  logic [MAX_LEN-1:0][7:0] shadow_q, shadow_d;
  logic [3:0]              slen_q, slen_d;
  logic                    long_q, long_d;
  logic [3:0]              widx_q, widx_d;
  logic [5:0]              type_q, type_d;
  logic [15:0]             count_q, count_d;
  logic [31:0]             payload_q, payload_d;
  logic                    req_q, req_d;
  logic                    unmapped_q, unmapped_d;
  logic                    overrun_q, overrun_d;

  logic       rd_req;
  logic       hit;
  logic [1:0] sel;
  logic [3:0] len_sat;
  logic [3:0] eff_len;

  assign rd_req = mipi_periph_rx_cmd_valid &&
                  (mipi_periph_rx_cmd[5:0] == 6'h06 || mipi_periph_rx_cmd[5:0] == 6'h14);

  logic unused_rx;
  assign unused_rx = ^{mipi_periph_rx_cmd[23:16], mipi_periph_rx_cmd[7:6]};

  // Lowest matching entry index wins.
  always_comb begin
    hit = 1'b0;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (key_q[i] == addr_q) begin
        hit = 1'b1;
        sel = 2'(i);
      end
    end
  end

  assign len_sat = (len_q[sel] > MaxLen8) ? MaxLen4 : len_q[sel][3:0];
  assign eff_len = hit ? len_sat : 4'd0;

  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    addr_d     = addr_q;
    shadow_d   = shadow_q;
    slen_d     = slen_q;
    long_d     = long_q;
    widx_d     = widx_q;
    type_d     = type_q;
    count_d    = count_q;
    payload_d  = payload_q;
    req_d      = req_q;
    unmapped_d = 1'b0;
    overrun_d  = rd_req && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          gen_d   = (mipi_periph_rx_cmd[5:0] == 6'h14);
          addr_d  = mipi_periph_rx_cmd[15:8];
          state_d = StLookup;
        end
      end
      StLookup: begin
        shadow_d  = hit ? tbl_q[sel] : '0;
        slen_d    = eff_len;
        long_d    = (eff_len >= 4'd3);
        widx_d    = 4'd0;
        payload_d = '0;
        if (eff_len == 4'd0) begin
          type_d     = gen_q ? 6'h11 : 6'h21;
          count_d    = 16'h0000;
          unmapped_d = 1'b1;
        end else if (eff_len == 4'd1) begin
          type_d  = gen_q ? 6'h11 : 6'h21;
          count_d = {8'h00, tbl_q[sel][0]};
        end else if (eff_len == 4'd2) begin
          type_d  = gen_q ? 6'h12 : 6'h22;
          count_d = {tbl_q[sel][1], tbl_q[sel][0]};
        end else begin
          type_d    = gen_q ? 6'h1A : 6'h1C;
          count_d   = {12'h000, eff_len};
          payload_d = pack_word(tbl_q[sel], eff_len, 4'd0);
        end
        state_d = StArmed;
      end
      StArmed: begin
        if (dir_q && !mipi_periph_dphy_direction) begin
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mipi_periph_tx_cmd_ack) begin
          req_d   = 1'b0;
          state_d = long_q ? StStream : StIdle;
        end
      end
      StStream: begin
        if (mipi_periph_tx_payload_en) begin
          if (mipi_periph_tx_payload_en_last) begin
            payload_d = '0;
            state_d   = StIdle;
          end else begin
            // Saturate so an overrun keeps reading zeros instead of wrapping.
            widx_d    = (widx_q == 4'hF) ? widx_q : widx_q + 4'd1;
            payload_d = pack_word(shadow_q, slen_q, widx_d);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_periph or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      gen_q      <= 1'b0;
      addr_q     <= '0;
      shadow_q   <= '0;
      slen_q     <= '0;
      long_q     <= 1'b0;
      widx_q     <= '0;
      type_q     <= '0;
      count_q    <= '0;
      payload_q  <= '0;
      req_q      <= 1'b0;
      unmapped_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= mipi_periph_dphy_direction;
      gen_q      <= gen_d;
      addr_q     <= addr_d;
      shadow_q   <= shadow_d;
      slen_q     <= slen_d;
      long_q     <= long_d;
      widx_q     <= widx_d;
      type_q     <= type_d;
      count_q    <= count_d;
      payload_q  <= payload_d;
      req_q      <= req_d;
      unmapped_q <= unmapped_d;
      overrun_q  <= overrun_d;
    end
  end

  assign mipi_periph_tx_payload        = payload_q;
  assign mipi_periph_tx_cmd_vc         = VC;
  assign mipi_periph_tx_cmd_data_type  = type_q;
  assign mipi_periph_tx_cmd_byte_count = count_q;
  assign mipi_periph_tx_cmd_req        = req_q;
  assign busy                          = (state_q != StIdle);
  assign err_unmapped                  = unmapped_q;
  assign err_overrun                   = overrun_q;

endmodule

// File: tb/tb_dcs_reg_resp_streamer.sv
// Self-checking bench for dcs_reg_resp_streamer: directed scenarios plus randomized table/read
// traffic checked against a table-lookup reference model.
module tb_dcs_reg_resp_streamer;
  localparam int MAXL = 12;

  logic        clk_periph = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] rx_cmd = '0;
  logic        rx_valid = 1'b0;
  logic        direction = 1'b1;
  logic        ack = 1'b0;
  logic        pen = 1'b0;
  logic        plast = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic [31:0] payload;
  logic [1:0]  vc;
  logic [5:0]  dtype;
  logic [15:0] bcount;
  logic        req, busy, err_unmapped, err_overrun;

  int checks = 0;
  int failures = 0;

  // Reference model: table contents and the response resolved for the current read
  logic [7:0] m_key [4];
  logic [7:0] m_len [4];
  logic [7:0] m_dat [4][16];
  logic [7:0] s_b [16];
  int         s_L;
  int         s_e;

  dcs_reg_resp_streamer #(.VC(2'd0), .MAX_LEN(MAXL)) dut (
    .clk_periph                     (clk_periph),
    .rstn                           (rstn),
    .mipi_periph_rx_cmd             (rx_cmd),
    .mipi_periph_rx_cmd_valid       (rx_valid),
    .mipi_periph_dphy_direction     (direction),
    .mipi_periph_tx_cmd_ack         (ack),
    .mipi_periph_tx_payload_en      (pen),
    .mipi_periph_tx_payload_en_last (plast),
    .cfg_wr_en                      (cfg_wr_en),
    .cfg_addr                       (cfg_addr),
    .cfg_wdata                      (cfg_wdata),
    .mipi_periph_tx_payload         (payload),
    .mipi_periph_tx_cmd_vc          (vc),
    .mipi_periph_tx_cmd_data_type   (dtype),
    .mipi_periph_tx_cmd_byte_count  (bcount),
    .mipi_periph_tx_cmd_req         (req),
    .busy                           (busy),
    .err_unmapped                   (err_unmapped),
    .err_overrun                    (err_overrun)
  );

  always #5 clk_periph = ~clk_periph;

  task automatic tick();
    @(posedge clk_periph);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = 8'h00;
      m_len[i] = 8'h00;
      for (int j = 0; j < 16; j++) m_dat[i][j] = 8'h00;
    end
  endtask

  task automatic cfg_wr(input int e, input int f, input logic [7:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = {2'(e), 4'(f)};
    cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
    if (f == 0) m_key[e] = d;
    else if (f == 1) m_len[e] = d;
    else if (f <= MAXL + 1) m_dat[e][f-2] = d;
  endtask

  task automatic resolve(input logic [7:0] addr);
    s_e = -1;
    s_L = 0;
    for (int i = 0; i < 4; i++) if (s_e < 0 && m_key[i] == addr) s_e = i;
    for (int j = 0; j < 16; j++) s_b[j] = 8'h00;
    if (s_e >= 0) begin
      s_L = (int'(m_len[s_e]) > MAXL) ? MAXL : int'(m_len[s_e]);
      for (int j = 0; j < MAXL; j++) s_b[j] = m_dat[s_e][j];
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (4 * w + k < s_L) r[8*k +: 8] = s_b[4*w+k];
    end
    return r;
  endfunction

  // One full read transaction. abort_w >= 0 asserts reset before streaming word abort_w.
  task automatic do_read(input logic [7:0] addr, input bit gen, input int extra,
                         input bit ovr_armed, input bit cfg_mid, input bit last_coinc,
                         input int abort_w);
    logic [5:0]  et;
    logic [15:0] ec;
    logic [31:0] ep;
    int          nw;
    resolve(addr);
    if (s_L <= 1)      et = gen ? 6'h11 : 6'h21;
    else if (s_L == 2) et = gen ? 6'h12 : 6'h22;
    else               et = gen ? 6'h1A : 6'h1C;
    if (s_L == 0)      ec = 16'h0000;
    else if (s_L == 1) ec = {8'h00, s_b[0]};
    else if (s_L == 2) ec = {s_b[1], s_b[0]};
    else               ec = 16'(s_L);
    ep = (s_L >= 3) ? exp_word(0) : 32'h0;

    direction = 1'b1;
    rx_cmd    = {8'h00, addr, 2'b00, gen ? 6'h14 : 6'h06};
    rx_valid  = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    checks += 5;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL armed_busy addr=%h: got %b want 1", addr, busy);
    end
    if (dtype !== et) begin
      failures++; $display("FAIL data_type addr=%h: got %h want %h", addr, dtype, et);
    end
    if (bcount !== ec) begin
      failures++; $display("FAIL byte_count addr=%h: got %h want %h", addr, bcount, ec);
    end
    if (payload !== ep) begin
      failures++; $display("FAIL preload addr=%h: got %h want %h", addr, payload, ep);
    end
    if (err_unmapped !== (s_L == 0)) begin
      failures++;
      $display("FAIL err_unmapped addr=%h: got %b want %b", addr, err_unmapped, s_L == 0);
    end

    if (ovr_armed) begin
      rx_cmd   = {8'h00, 8'h3C, 2'b00, 6'h06};
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      checks += 3;
      if (err_overrun !== 1'b1) begin
        failures++; $display("FAIL overrun_armed: got %b want 1", err_overrun);
      end
      if (dtype !== et || bcount !== ec) begin
        failures++;
        $display("FAIL overrun_kept: got %h/%h want %h/%h", dtype, bcount, et, ec);
      end
      tick();
      if (err_overrun !== 1'b0) begin
        failures++; $display("FAIL overrun_pulse_width: got %b want 0", err_overrun);
      end
    end

    checks += 1;
    if (req !== 1'b0) begin
      failures++; $display("FAIL req_before_turn: got %b want 0", req);
    end
    direction = 1'b0;
    tick();
    checks += 1;
    if (req !== 1'b1) begin
      failures++; $display("FAIL req_set: got %b want 1", req);
    end
    repeat ($urandom_range(0, 2)) tick();
    checks += 1;
    if (req !== 1'b1) begin
      failures++; $display("FAIL req_hold: got %b want 1", req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    direction = 1'b1;
    checks += 1;
    if (req !== 1'b0) begin
      failures++; $display("FAIL req_clear: got %b want 0", req);
    end

    if (s_L >= 3) begin
      nw = (s_L + 3) / 4 + extra;
      for (int w = 0; w < nw; w++) begin
        if (w == abort_w) begin
          #2 rstn = 1'b0;
          #1;
          checks += 1;
          if (req !== 1'b0 || payload !== 32'h0 || dtype !== 6'h0 || bcount !== 16'h0 ||
              busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stream: got req=%b pl=%h dt=%h bc=%h busy=%b want all 0",
                     req, payload, dtype, bcount, busy);
          end
          model_clear();
          tick();
          rstn = 1'b1;
          tick();
          return;
        end
        checks += 1;
        if (payload !== exp_word(w)) begin
          failures++;
          $display("FAIL stream_word%0d addr=%h: got %h want %h", w, addr, payload, exp_word(w));
        end
        if (cfg_mid && w == 0 && s_e >= 0) begin
          for (int f = 2; f < 6; f++) cfg_wr(s_e, f, 8'hEE);
        end
        if ($urandom_range(0, 1) == 1) tick();
        pen   = 1'b1;
        plast = (w == nw - 1);
        if (plast && last_coinc) begin
          rx_cmd   = {8'h00, addr, 2'b00, 6'h06};
          rx_valid = 1'b1;
        end
        tick();
        pen = 1'b0;
        plast = 1'b0;
        rx_valid = 1'b0;
      end
      checks += 1;
      if (payload !== 32'h0) begin
        failures++; $display("FAIL payload_after_last: got %h want 0", payload);
      end
      if (last_coinc) begin
        checks += 1;
        if (err_overrun !== 1'b1) begin
          failures++; $display("FAIL overrun_last_beat: got %b want 1", err_overrun);
        end
      end
    end
    checks += 1;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_read addr=%h: got %b want 0", addr, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_clear();
    tick();
    checks += 1;
    if (payload !== 32'h0 || dtype !== 6'h0 || bcount !== 16'h0 || req !== 1'b0 ||
        busy !== 1'b0 || err_unmapped !== 1'b0 || err_overrun !== 1'b0 || vc !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got pl=%h dt=%h bc=%h req=%b busy=%b want all 0",
               payload, dtype, bcount, req, busy);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_short();
    cfg_wr(0, 0, 8'hDA);
    cfg_wr(0, 1, 8'd1);
    cfg_wr(0, 2, 8'h5E);
    do_read(8'hDA, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    cfg_wr(0, 1, 8'd2);
    cfg_wr(0, 3, 8'hC3);
    do_read(8'hDA, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_long();
    cfg_wr(1, 0, 8'hA0);
    cfg_wr(1, 1, 8'd10);
    for (int j = 0; j < 10; j++) cfg_wr(1, j + 2, 8'(j + 1));
    do_read(8'hA0, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_unmapped();
    do_read(8'h55, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overrun_and_snapshot();
    do_read(8'hA0, 1'b0, 1, 1'b1, 1'b1, 1'b1, -1);
  endtask

  task automatic test_dup_and_idle_payload();
    cfg_wr(2, 0, 8'h77);
    cfg_wr(2, 1, 8'd5);
    cfg_wr(3, 0, 8'h77);
    cfg_wr(3, 1, 8'd7);
    for (int j = 0; j < 7; j++) begin
      cfg_wr(2, j + 2, 8'(8'h20 + j));
      cfg_wr(3, j + 2, 8'(8'h90 + j));
    end
    do_read(8'h77, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    pen = 1'b1;
    plast = 1'b1;
    repeat (3) tick();
    pen = 1'b0;
    plast = 1'b0;
    checks += 1;
    if (payload !== 32'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_payload_en: got pl=%h busy=%b want 0/0", payload, busy);
    end
    rx_cmd   = {8'h00, 8'h77, 2'b00, 6'h05};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    checks += 1;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL ignored_type: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int f;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 6)) begin
        f = $urandom_range(0, 15);
        if (f == 0)      d = 8'(8'h30 + $urandom_range(0, 3));
        else if (f == 1) d = 8'($urandom_range(0, 15));
        else             d = 8'($urandom);
        cfg_wr($urandom_range(0, 3), f, d);
      end
      do_read(8'(8'h30 + $urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 1), 1'b0, 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_stream();
    cfg_wr(1, 0, 8'hA0);
    cfg_wr(1, 1, 8'd10);
    do_read(8'hA0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1);
    do_read(8'hA0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_unmapped();
    test_overrun_and_snapshot();
    test_dup_and_idle_payload();
    test_random();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
